instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the instruction register interface: fetches 32-bit instruction words from instruction memory and delivers each one with a one-cycle IRWrite strobe.
- Holds the PC, increments it by 4 per completed fetch, and accepts PC redirects (branch/jump) from the control unit.
- Sits between the control FSM, instruction memory, and the instruction register.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 16, max cycles waiting for mem_ready before fault; 0 disables timeout.

Ports:
- clock  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  request the next fetch; sampled only in IDLE.
- pc_load  input  1  redirect PC to pc_in.
- pc_in  input  ADDR_WIDTH  redirect target.
- mem_req  output  1  memory read request, registered.
- mem_addr  output  ADDR_WIDTH  read address; equals pc while mem_req=1.
- mem_ready  input  1  memory data valid; meaningful only while mem_req=1.
- mem_rdata  input  32  memory read data.
- IRWrite  output  1  one-cycle write strobe to the instruction register.
- Instr_out  output  32  fetched word; valid whenever IRWrite=1, held otherwise.
- pc  output  ADDR_WIDTH  current PC.
- busy  output  1  high in REQ state.
- fetch_fault  output  1  sticky timeout flag.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, pc=RESET_PC.
  - mem_req=0, IRWrite=0, Instr_out=0, busy=0, fetch_fault=0, timeout count=0.
  - Reset during REQ drops mem_req at that edge; any data returned afterwards is ignored.
- States: IDLE, REQ, FAULT.
- IDLE:
  - pc_load=1 sets pc<=pc_in.
  - fetch_en=1 goes to REQ with mem_req=1 next cycle.
  - If pc_load and fetch_en are both high, the fetch uses pc_in (mem_addr=pc_in).
- REQ:
  - mem_req=1, busy=1, mem_addr=pc, count increments each cycle.
  - Edge with mem_ready=1 and no pc_load:
    - Instr_out<=mem_rdata, IRWrite<=1 for exactly the next cycle.
    - pc<=pc+4, modulo 2^ADDR_WIDTH; 0xFFFFFFFC wraps to 0.
    - State to IDLE, mem_req<=0, count cleared.
- pc_load in REQ:
  - In-flight fetch is abandoned, even if mem_ready is high in the same cycle.
  - No IRWrite; Instr_out unchanged.
  - pc<=pc_in; stay in REQ with count cleared, reissuing at the new address next cycle.
  - pc_load takes priority over mem_ready.
- Timeout:
  - TIMEOUT>0 and count reaches TIMEOUT with no mem_ready: go to FAULT.
  - mem_req<=0, fetch_fault<=1.
- FAULT:
  - All inputs ignored except reset.
  - mem_req=0, IRWrite=0, fetch_fault=1 until reset.
- fetch_en outside IDLE is ignored; it is not queued.
- Latency: fetch_en sampled at edge N gives mem_req=1 in cycle N+1. With mem_ready already high in N+1, IRWrite=1 in cycle N+2 (2-cycle minimum). Each wait cycle adds 1.
- IRWrite never asserts on two consecutive cycles.
- Instr_out field layout (consumer side):
  - opcode [31:26]
  - R1 [25:21]
  - R2 [20:16]
  - R3 [15:11]
  - immediate [15:0]
  - This block does not decode fields.

Decomposition:
- Shared CPU package holds:
  - fetch state enum (IDLE, REQ, FAULT)
  - INSTR_WIDTH=32
  - PC_INCR=4
  - opcode/field bit-position constants shared with the instruction register and control unit.
- One sub-module, fetch_timeout_counter: clear, enable, TIMEOUT parameter, expired output.
- PC and FSM stay in the top module.

Test Plan:
- Reset, then fetch_en with mem_ready held 1 and mem_rdata=0x8C220004 -> mem_addr=0x0; IRWrite pulses 2 cycles after fetch_en, Instr_out=0x8C220004, pc=0x4.
- mem_ready delayed 3 cycles, rdata=0x00A63820 -> mem_req high for 4 cycles, IRWrite single pulse, pc 0x4->0x8.
- In REQ at pc=0x8, pc_load=1 with pc_in=0x40 in the same cycle as mem_ready=1 -> no IRWrite; next mem_addr=0x40; completion gives pc=0x44.
- pc_load pc_in=0xFFFFFFFC, then a fetch completes -> pc=0x00000000.
- TIMEOUT=16 with mem_ready never asserted -> fetch_fault=1 after 16 REQ cycles, mem_req=0, later fetch_en ignored; reset clears the fault and pc=RESET_PC.
- Reset asserted mid-REQ with mem_ready arriving the next cycle -> no IRWrite, mem_req=0, Instr_out=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction width, PC step and
// instruction-word field positions used by the fetch unit, instruction
// register and control unit.
package instr_fetch_unit_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_INCR     = 4;

    // Instruction word field positions (consumer side; not decoded here).
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int R1_MSB     = 25;
    localparam int R1_LSB     = 21;
    localparam int R2_MSB     = 20;
    localparam int R2_LSB     = 16;
    localparam int R3_MSB     = 15;
    localparam int R3_LSB     = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_timeout_counter.sv
// Counts cycles spent waiting for memory; flags expiry on the TIMEOUT-th
// enabled cycle. TIMEOUT=0 disables expiry entirely.
module fetch_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over increment.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count_q == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one memory read per fetch
// request, and delivers the returned word with a one-cycle IRWrite strobe.
// PC redirects abandon an in-flight read; a memory timeout parks the unit
// in FAULT until reset.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_en,
    input  logic                   pc_load,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   IRWrite,
    output logic [INSTR_WIDTH-1:0] Instr_out,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   busy,
    output logic                   fetch_fault
);

    fetch_state_e           state_q,   state_d;
    logic [ADDR_WIDTH-1:0]  pc_q,      pc_d;
    logic                   mem_req_q, mem_req_d;
    logic                   irwrite_q, irwrite_d;
    logic [INSTR_WIDTH-1:0] instr_q,   instr_d;
    logic                   fault_q,   fault_d;

    logic tmo_clear;
    logic tmo_expired;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (state_q == FETCH_REQ),
        .expired (tmo_expired)
    );

    // Next-state and datapath: redirect beats completion, completion beats timeout.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        irwrite_d = 1'b0;
        instr_d   = instr_q;
        fault_d   = fault_q;
        tmo_clear = 1'b1;

        unique case (state_q)
            FETCH_IDLE: begin
                if (pc_load) begin
                    pc_d = pc_in;
                end
                if (fetch_en) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                tmo_clear = 1'b0;
                if (pc_load) begin
                    // Abandon the in-flight read and reissue at the new PC.
                    pc_d      = pc_in;
                    tmo_clear = 1'b1;
                end else if (mem_ready) begin
                    instr_d   = mem_rdata;
                    irwrite_d = 1'b1;
                    pc_d      = pc_q + ADDR_WIDTH'(PC_INCR);
                    state_d   = FETCH_IDLE;
                    tmo_clear = 1'b1;
                end else if (tmo_expired) begin
                    state_d   = FETCH_FAULT;
                    fault_d   = 1'b1;
                    tmo_clear = 1'b1;
                end
            end
            FETCH_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase

        mem_req_d = (state_d == FETCH_REQ);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= RESET_PC;
            mem_req_q <= 1'b0;
            irwrite_q <= 1'b0;
            instr_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mem_req_q <= mem_req_d;
            irwrite_q <= irwrite_d;
            instr_q   <= instr_d;
            fault_q   <= fault_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign IRWrite     = irwrite_q;
    assign Instr_out   = instr_q;
    assign pc          = pc_q;
    assign busy        = (state_q == FETCH_REQ);
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset;
    logic        fetch_en;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        IRWrite;
    logic [31:0] Instr_out;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0),
        .TIMEOUT    (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .IRWrite     (IRWrite),
        .Instr_out   (Instr_out),
        .pc          (pc),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock edge; outputs are sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        fetch_en  = 1'b0;
        pc_load   = 1'b0;
        pc_in     = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_pc",      pc,          32'h0);
        check("rst_mem_req", mem_req,     32'h0);
        check("rst_irwrite", IRWrite,     32'h0);
        check("rst_instr",   Instr_out,   32'h0);
        check("rst_busy",    busy,        32'h0);
        check("rst_fault",   fetch_fault, 32'h0);

        // Minimum-latency fetch: ready already high
        fetch_en  = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h8C220004;
        step();
        fetch_en = 1'b0;
        check("t1_mem_req",  mem_req,  32'h1);
        check("t1_mem_addr", mem_addr, 32'h0);
        check("t1_busy",     busy,     32'h1);
        check("t1_irw_early", IRWrite, 32'h0);
        step();
        check("t1_irwrite",  IRWrite,   32'h1);
        check("t1_instr",    Instr_out, 32'h8C220004);
        check("t1_pc",       pc,        32'h4);
        check("t1_req_drop", mem_req,   32'h0);
        step();
        check("t1_irw_pulse", IRWrite,  32'h0);
        check("t1_instr_hold", Instr_out, 32'h8C220004);

        // Three wait cycles before ready
        mem_ready = 1'b0;
        mem_rdata = 32'h00A63820;
        fetch_en  = 1'b1;
        step();
        fetch_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_req_c%0d", i), mem_req, 32'h1);
            check($sformatf("t2_irw_c%0d", i), IRWrite, 32'h0);
            check($sformatf("t2_addr_c%0d", i), mem_addr, 32'h4);
            if (i == 3) mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
        check("t2_irwrite", IRWrite,   32'h1);
        check("t2_instr",   Instr_out, 32'h00A63820);
        check("t2_pc",      pc,        32'h8);
        check("t2_req_low", mem_req,   32'h0);
        step();
        check("t2_irw_pulse", IRWrite, 32'h0);

        // Redirect in REQ wins over simultaneous mem_ready
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        check("t3_addr_pre", mem_addr, 32'h8);
        pc_load   = 1'b1;
        pc_in     = 32'h40;
        mem_ready = 1'b1;
        mem_rdata = 32'hBADBAD00;
        step();
        pc_load = 1'b0;
        check("t3_no_irw",   IRWrite,   32'h0);
        check("t3_instr",    Instr_out, 32'h00A63820);
        check("t3_req",      mem_req,   32'h1);
        check("t3_addr",     mem_addr,  32'h40);
        mem_rdata = 32'h12345678;
        step();
        mem_ready = 1'b0;
        check("t3_irwrite",  IRWrite,   32'h1);
        check("t3_instr2",   Instr_out, 32'h12345678);
        check("t3_pc",       pc,        32'h44);

        // Load + fetch together in IDLE, then PC wraps
        pc_load  = 1'b1;
        pc_in    = 32'hFFFFFFFC;
        fetch_en = 1'b1;
        step();
        pc_load  = 1'b0;
        fetch_en = 1'b0;
        check("t4_addr", mem_addr, 32'hFFFFFFFC);
        check("t4_req",  mem_req,  32'h1);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_ready = 1'b0;
        check("t4_irwrite", IRWrite,   32'h1);
        check("t4_pc_wrap", pc,        32'h0);
        check("t4_instr",   Instr_out, 32'hDEADBEEF);
        step();

        // Timeout: 16 REQ cycles without ready, fetch_en held (ignored in REQ)
        pc_load  = 1'b1;
        pc_in    = 32'h100;
        fetch_en = 1'b1;
        step();
        pc_load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t5_req_c%0d", i), mem_req, 32'h1);
            check($sformatf("t5_nofault_c%0d", i), fetch_fault, 32'h0);
            step();
        end
        check("t5_fault",    fetch_fault, 32'h1);
        check("t5_req_low",  mem_req,     32'h0);
        check("t5_busy_low", busy,        32'h0);
        pc_load   = 1'b1;
        pc_in     = 32'h200;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5_ign_req_%0d", i),   mem_req,     32'h0);
            check($sformatf("t5_ign_irw_%0d", i),   IRWrite,     32'h0);
            check($sformatf("t5_ign_fault_%0d", i), fetch_fault, 32'h1);
            check($sformatf("t5_ign_pc_%0d", i),    pc,          32'h100);
        end
        fetch_en  = 1'b0;
        pc_load   = 1'b0;
        mem_ready = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        check("t5_rst_fault", fetch_fault, 32'h0);
        check("t5_rst_pc",    pc,          32'h0);
        check("t5_rst_instr", Instr_out,   32'h0);

        // Reset mid-REQ, data arriving afterwards is ignored
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        check("t6_req", mem_req, 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_req_drop", mem_req, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hAAAA5555;
        step();
        mem_ready = 1'b0;
        check("t6_no_irw", IRWrite,   32'h0);
        check("t6_req",    mem_req,   32'h0);
        check("t6_instr",  Instr_out, 32'h0);
        check("t6_pc",     pc,        32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
